// File: rtl/rf_scoreboard_pkg.sv
// Shared widths and forwarding-bus channel ordering for the RAW scoreboard and
// the EX/MEM stage bus packers.
package rf_scoreboard_pkg;

  localparam int unsigned SB_AW    = 5;
  localparam int unsigned SB_DW    = 32;
  localparam int unsigned SB_CNT_W = 2;

  // Lower channel index is younger; packers place EX in channel 0.
  localparam int unsigned FWD_CH_EX  = 0;
  localparam int unsigned FWD_CH_MEM = 1;
  localparam int unsigned SB_NFWD    = FWD_CH_MEM + 1;

  // LSB position of channel ch on a bus packed with fields of the given width.
  function automatic int unsigned chan_lo(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard_fwd_select.sv
// Priority forwarding match for one source operand: channels (youngest first),
// then the writeback bypass, then the regfile.
module rf_scoreboard_fwd_select
  import rf_scoreboard_pkg::*;
#(
  parameter int unsigned AW   = SB_AW,
  parameter int unsigned DW   = SB_DW,
  parameter int unsigned NFWD = SB_NFWD
) (
  input  logic [AW-1:0]      idx,
  input  logic [NFWD-1:0]    fwd_valid,
  input  logic [NFWD-1:0]    fwd_ready,
  input  logic [NFWD*AW-1:0] fwd_reg,
  input  logic [NFWD*DW-1:0] fwd_data,
  input  logic               wb_valid,
  input  logic [AW-1:0]      wb_reg,
  input  logic [DW-1:0]      wb_data,
  input  logic [DW-1:0]      rf_rdata,
  output logic [DW-1:0]      value,
  output logic               hit,
  output logic               hit_ready
);

  // Walk oldest to youngest so the youngest match overwrites; WB is older than all channels.
  always_comb begin
    value     = rf_rdata;
    hit       = 1'b0;
    hit_ready = 1'b0;
    if (wb_valid && wb_reg == idx) begin
      value     = wb_data;
      hit       = 1'b1;
      hit_ready = 1'b1;
    end
    for (int k = int'(NFWD) - 1; k >= int'(FWD_CH_EX); k--) begin
      if (fwd_valid[k] && fwd_reg[chan_lo(k, AW) +: AW] == idx) begin
        value     = fwd_data[chan_lo(k, DW) +: DW];
        hit       = 1'b1;
        hit_ready = fwd_ready[k];
      end
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Decode-stage RAW hazard unit: per-register pending-writer counters, operand
// forwarding select and decode stall.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW,
  parameter int unsigned NFWD  = SB_NFWD,
  parameter int unsigned CNT_W = SB_CNT_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ds_valid,
  input  logic               ds_fire,
  input  logic               ds_src1_need,
  input  logic [AW-1:0]      ds_src1,
  input  logic               ds_src2_need,
  input  logic [AW-1:0]      ds_src2,
  input  logic               ds_gr_we,
  input  logic [AW-1:0]      ds_dest,
  input  logic [DW-1:0]      rf_rdata1,
  input  logic [DW-1:0]      rf_rdata2,
  input  logic [NFWD-1:0]    fwd_valid,
  input  logic [NFWD-1:0]    fwd_ready,
  input  logic [NFWD*AW-1:0] fwd_reg,
  input  logic [NFWD*DW-1:0] fwd_data,
  input  logic               wb_valid,
  input  logic [AW-1:0]      wb_reg,
  input  logic [DW-1:0]      wb_data,
  input  logic               flush,
  output logic [DW-1:0]      src1_value,
  output logic [DW-1:0]      src2_value,
  output logic               ds_stall,
  output logic               sb_err
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             sb_err_q, sb_err_d;

  logic [DW-1:0] sel1_value, sel2_value;
  logic          hit1, hit1_ready, hit2, hit2_ready;
  logic          stall1, stall2, full;
  logic          inc, dec;

  rf_scoreboard_fwd_select #(
    .AW   (AW),
    .DW   (DW),
    .NFWD (NFWD)
  ) u_fwd_select_src1 (
    .idx       (ds_src1),
    .fwd_valid (fwd_valid),
    .fwd_ready (fwd_ready),
    .fwd_reg   (fwd_reg),
    .fwd_data  (fwd_data),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .rf_rdata  (rf_rdata1),
    .value     (sel1_value),
    .hit       (hit1),
    .hit_ready (hit1_ready)
  );

  rf_scoreboard_fwd_select #(
    .AW   (AW),
    .DW   (DW),
    .NFWD (NFWD)
  ) u_fwd_select_src2 (
    .idx       (ds_src2),
    .fwd_valid (fwd_valid),
    .fwd_ready (fwd_ready),
    .fwd_reg   (fwd_reg),
    .fwd_data  (fwd_data),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .rf_rdata  (rf_rdata2),
    .value     (sel2_value),
    .hit       (hit2),
    .hit_ready (hit2_ready)
  );

  // A pending writer with no ready producer on the youngest match blocks the read.
  always_comb begin
    stall1 = ds_src1_need && ds_src1 != '0 && cnt_q[ds_src1] != '0 && (!hit1 || !hit1_ready);
    stall2 = ds_src2_need && ds_src2 != '0 && cnt_q[ds_src2] != '0 && (!hit2 || !hit2_ready);
    full   = ds_gr_we && ds_dest != '0 && cnt_q[ds_dest] == CntMax;
    ds_stall   = ds_valid && (stall1 || stall2 || full);
    src1_value = (ds_src1 == '0) ? '0 : sel1_value;
    src2_value = (ds_src2 == '0) ? '0 : sel2_value;
  end

  always_comb begin
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;
    inc      = ds_fire && ds_gr_we && ds_dest != '0 && !ds_stall;
    dec      = wb_valid && wb_reg != '0;
    if (ds_fire && ds_stall) begin
      sb_err_d = 1'b1;
    end
    if (flush) begin
      for (int r = 0; r < int'(NREG); r++) begin
        cnt_d[r] = '0;
      end
    end else if (!(inc && dec && ds_dest == wb_reg)) begin
      if (inc) begin
        if (cnt_q[ds_dest] == CntMax) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[ds_dest] = cnt_q[ds_dest] + 1'b1;
        end
      end
      if (dec) begin
        if (cnt_q[wb_reg] == '0) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[wb_reg] = cnt_q[wb_reg] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < int'(NREG); r++) begin
        cnt_q[r] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

endmodule
